// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Entry fields use fixed maximum widths so that one packed type serves every
// parameterisation. rd holds up to 8 bits of register address (REG_AW <= 8).
// ready_stage holds up to 3 bits (STAGES <= 8).
package hazard_pkg;

    localparam int HZ_RD_W  = 8;
    localparam int HZ_SEL_W = 3;

    localparam int FWD_REGFILE = 0;  // forward select: operand comes from the register file
    localparam int READY_EX    = 0;  // result exists at the end of EX (ALU)
    localparam int READY_MEM   = 1;  // result exists at the end of MEM (load)

    typedef struct packed {
        logic                valid;
        logic [HZ_RD_W-1:0]  rd;
        logic                wre;
        logic [HZ_SEL_W-1:0] ready_stage;
    } hz_entry_t;

    // Counts the operands (0..2) that receive a forwarded value.
    function automatic logic [1:0] nz_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/hazard_entry_match.sv
// Per-entry source/destination comparator for one in-flight table slot.
// Latency: combinational.
// Backpressure: none; the caller qualifies the results.
//
// Ports: i_entry (table slot), i_rs1/i_rs2 (zero-extended decode sources),
//        i_use_rs1/i_use_rs2 (operand is read), o_match_rs1/o_match_rs2.
module hazard_entry_match
    import hazard_pkg::*;
#(
    parameter int ZERO_REG = 0
) (
    input  hz_entry_t          i_entry,
    input  logic [HZ_RD_W-1:0] i_rs1,
    input  logic [HZ_RD_W-1:0] i_rs2,
    input  logic               i_use_rs1,
    input  logic               i_use_rs2,
    output logic               o_match_rs1,
    output logic               o_match_rs2
);

    logic w_writer;
    logic w_rs1_zero;
    logic w_rs2_zero;

    assign w_writer   = i_entry.valid && i_entry.wre;
    // When register 0 is hardwired, a write to it produces nothing to wait for.
    assign w_rs1_zero = (ZERO_REG != 0) && (i_rs1 == '0);
    assign w_rs2_zero = (ZERO_REG != 0) && (i_rs2 == '0);

    assign o_match_rs1 = w_writer && i_use_rs1 && !w_rs1_zero && (i_entry.rd == i_rs1);
    assign o_match_rs2 = w_writer && i_use_rs2 && !w_rs2_zero && (i_entry.rd == i_rs2);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for stages EX..WB; stall is combinational and forward selects are registered.
// Latency: stall_o 0 cycles; fwd_sel_*_o/ex_valid_o 1 cycle (they describe the instruction now in EX).
// Backpressure: stall_o holds PC and IF/ID and injects a bubble into EX; the table itself never holds.
//
// Ports: clk, reset (async, active-high); id_* decode-slot instruction;
//        stall_o, fwd_sel_a_o, fwd_sel_b_o, ex_valid_o; stall_cnt_o, fwd_cnt_o.
// Optional macro HAZARD_PERF_CNT_EN: saturating stall/forward counters (tied to 0 otherwise).
// Limits: STAGES 2..8, REG_AW <= 8.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_AW   = 4,
    parameter int SEL_W    = $clog2(STAGES),
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_wre_i,
    input  logic [SEL_W-1:0]  id_ready_stage_i,
    input  logic              id_is_branch_i,
    output logic              stall_o,
    output logic [SEL_W-1:0]  fwd_sel_a_o,
    output logic [SEL_W-1:0]  fwd_sel_b_o,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  fwd_cnt_o
);

    // Index 0 = EX, STAGES-1 = WB.
    hz_entry_t           r_tab [STAGES];
    logic [SEL_W-1:0]    r_sel_a;
    logic [SEL_W-1:0]    r_sel_b;

    logic [HZ_RD_W-1:0]  w_rs1_ext;
    logic [HZ_RD_W-1:0]  w_rs2_ext;
    logic [HZ_RD_W-1:0]  w_rd_ext;
    logic [HZ_SEL_W-1:0] w_rdy_ext;
    logic [STAGES-1:0]   w_m1;
    logic [STAGES-1:0]   w_m2;
    logic                w_data_stall;
    logic                w_br_hit;
    logic                w_capture;
    hz_entry_t           w_new;
    logic [SEL_W-1:0]    w_nxt_a;
    logic [SEL_W-1:0]    w_nxt_b;

    always_comb begin
        w_rs1_ext = '0;
        w_rs2_ext = '0;
        w_rd_ext  = '0;
        w_rdy_ext = '0;
        w_rs1_ext[REG_AW-1:0] = id_rs1_i;
        w_rs2_ext[REG_AW-1:0] = id_rs2_i;
        w_rd_ext[REG_AW-1:0]  = id_rd_i;
        w_rdy_ext[SEL_W-1:0]  = id_ready_stage_i;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_match
        hazard_entry_match #(
            .ZERO_REG (ZERO_REG)
        ) u_match (
            .i_entry     (r_tab[g]),
            .i_rs1       (w_rs1_ext),
            .i_rs2       (w_rs2_ext),
            .i_use_rs1   (id_use_rs1_i),
            .i_use_rs2   (id_use_rs2_i),
            .o_match_rs1 (w_m1[g]),
            .o_match_rs2 (w_m2[g])
        );
    end

    // Data stall: the producer at slot i has not yet finished its ready stage.
    // Branch stall: decode compares operands itself, so any producer short of
    // WB must drain first; the WB write reaches decode via the register file.
    always_comb begin
        w_data_stall = 1'b0;
        w_br_hit     = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if ((w_m1[i] || w_m2[i]) && (i < int'(r_tab[i].ready_stage))) begin
                w_data_stall = 1'b1;
            end
            if ((w_m1[i] || w_m2[i]) && (i <= STAGES - 2)) begin
                w_br_hit = 1'b1;
            end
        end
    end

    assign stall_o   = id_valid_i && (w_data_stall || (id_is_branch_i && w_br_hit));
    assign w_capture = id_valid_i && !stall_o;

    always_comb begin
        w_new = '0;
        if (w_capture) begin
            w_new.valid       = 1'b1;
            w_new.rd          = w_rd_ext;
            w_new.wre         = id_wre_i;
            w_new.ready_stage = w_rdy_ext;
        end
    end

    // Next cycle the producer now at slot i sits at stage i+1. It can forward
    // once it has passed its ready stage. The scan runs from old to young so the
    // youngest match is written last and wins. WB (STAGES-1) is excluded: it has retired.
    always_comb begin
        w_nxt_a = SEL_W'(FWD_REGFILE);
        w_nxt_b = SEL_W'(FWD_REGFILE);
        for (int i = STAGES - 2; i >= 0; i--) begin
            if (w_m1[i] && (i + 1 > int'(r_tab[i].ready_stage))) begin
                w_nxt_a = SEL_W'(i + 1);
            end
            if (w_m2[i] && (i + 1 > int'(r_tab[i].ready_stage))) begin
                w_nxt_b = SEL_W'(i + 1);
            end
        end
        if (!w_capture) begin
            w_nxt_a = SEL_W'(FWD_REGFILE);
            w_nxt_b = SEL_W'(FWD_REGFILE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_tab[i] <= '0;
            end
            r_sel_a <= '0;
            r_sel_b <= '0;
        end else begin
            r_tab[0] <= w_new;
            for (int i = 1; i < STAGES; i++) begin
                r_tab[i] <= r_tab[i-1];
            end
            r_sel_a <= w_nxt_a;
            r_sel_b <= w_nxt_b;
        end
    end

    assign fwd_sel_a_o = r_sel_a;
    assign fwd_sel_b_o = r_sel_b;
    assign ex_valid_o  = r_tab[0].valid;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic [CNT_W:0]   w_fwd_sum;

    assign w_fwd_sum = {1'b0, r_fwd_cnt}
                     + (CNT_W+1)'(nz_count(w_nxt_a != '0, w_nxt_b != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            // A carry out of the sum means the counter would wrap; pin it at all-ones.
            r_fwd_cnt <= w_fwd_sum[CNT_W] ? '1 : w_fwd_sum[CNT_W-1:0];
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;
`else
    assign stall_cnt_o = '0;
    assign fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard.
// Two instances share the stimulus: dut0 (STAGES=3, ZERO_REG=0) and dut4 (STAGES=4, ZERO_REG=1).
// Each vector: stall_o is sampled before the edge; selects and ex_valid are sampled after it.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid_i;
    logic [3:0] id_rs1_i;
    logic [3:0] id_rs2_i;
    logic       id_use_rs1_i;
    logic       id_use_rs2_i;
    logic [3:0] id_rd_i;
    logic       id_wre_i;
    logic [1:0] id_ready_stage_i;
    logic       id_is_branch_i;

    logic        stall0, exv0, stall4, exv4;
    logic [1:0]  sa0, sb0, sa4, sb4;
    logic [31:0] scnt0, fcnt0, scnt4, fcnt4;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.STAGES(3), .REG_AW(4), .ZERO_REG(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_wre_i(id_wre_i), .id_ready_stage_i(id_ready_stage_i),
        .id_is_branch_i(id_is_branch_i), .stall_o(stall0), .fwd_sel_a_o(sa0),
        .fwd_sel_b_o(sb0), .ex_valid_o(exv0), .stall_cnt_o(scnt0), .fwd_cnt_o(fcnt0)
    );

    hazard_scoreboard #(.STAGES(4), .REG_AW(4), .ZERO_REG(1), .CNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_wre_i(id_wre_i), .id_ready_stage_i(id_ready_stage_i),
        .id_is_branch_i(id_is_branch_i), .stall_o(stall4), .fwd_sel_a_o(sa4),
        .fwd_sel_b_o(sb4), .ex_valid_o(exv4), .stall_cnt_o(scnt4), .fwd_cnt_o(fcnt4)
    );

    typedef struct {
        logic       vld;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic [3:0] rd;
        logic       wre;
        logic [1:0] rdy;
        logic       br;
        logic       e_stall;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic       c4;
        logic [1:0] e4_a;
        logic [1:0] e4_b;
    } vec_t;

    vec_t tbl[$];
    int   ph1_end;

    function automatic vec_t mk(input int vld, input int rs1, input int rs2, input int u1,
                                input int u2, input int rd, input int wre, input int rdy,
                                input int br, input int st, input int ea, input int eb);
        vec_t v;
        v.vld = 1'(vld);  v.rs1 = 4'(rs1);  v.rs2 = 4'(rs2);
        v.u1 = 1'(u1);    v.u2 = 1'(u2);    v.rd = 4'(rd);
        v.wre = 1'(wre);  v.rdy = 2'(rdy);  v.br = 1'(br);
        v.e_stall = 1'(st); v.e_a = 2'(ea); v.e_b = 2'(eb);
        v.c4 = 1'b0; v.e4_a = 2'd0; v.e4_b = 2'd0;
        return v;
    endfunction

    function automatic vec_t w4(input vec_t v, input int a4, input int b4);
        vec_t r;
        r = v;
        r.c4 = 1'b1; r.e4_a = 2'(a4); r.e4_b = 2'(b4);
        return r;
    endfunction

    function automatic vec_t bub();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t alu(input int rd);
        return mk(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid_i       = v.vld;
        id_rs1_i         = v.rs1;
        id_rs2_i         = v.rs2;
        id_use_rs1_i     = v.u1;
        id_use_rs2_i     = v.u2;
        id_rd_i          = v.rd;
        id_wre_i         = v.wre;
        id_ready_stage_i = v.rdy;
        id_is_branch_i   = v.br;
    endtask

    // Called 1 time unit after a rising edge.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #3;
        chk("stall", idx, 32'(stall0), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk("ex_valid", idx, 32'(exv0), 32'(v.vld && !v.e_stall));
        chk("sel_a", idx, 32'(sa0), 32'(v.e_a));
        chk("sel_b", idx, 32'(sb0), 32'(v.e_b));
        if (v.c4) begin
            chk("s4_sel_a", idx, 32'(sa4), 32'(v.e4_a));
            chk("s4_sel_b", idx, 32'(sb4), 32'(v.e4_b));
        end
    endtask

    initial begin
        drive(bub());
        reset = 1'b1;

        // Load-use: load r5 (ready at end of MEM), consumer reads r5.
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 1, 0, 0));
        tbl.push_back(w4(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 2, 0), 2, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(bub());
        // Branch on r2 behind an ALU producer: two stall cycles (EX, MEM).
        tbl.push_back(alu(2));
        tbl.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(bub());
        ph1_end = tbl.size();

        // Distance 1 forward on rs1.
        tbl.push_back(alu(3));
        tbl.push_back(w4(mk(1, 3, 0, 1, 0, 7, 1, 0, 0, 0, 1, 0), 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(bub());
        // Distance 2 forward on rs2.
        tbl.push_back(alu(3));
        tbl.push_back(alu(9));
        tbl.push_back(w4(mk(1, 0, 3, 0, 1, 10, 1, 0, 0, 0, 0, 2), 0, 2));
        for (int i = 0; i < 4; i++) tbl.push_back(bub());
        // Two gaps: producer in WB for STAGES=3 (no forward), in stage 3 for STAGES=4.
        tbl.push_back(alu(3));
        tbl.push_back(bub());
        tbl.push_back(bub());
        tbl.push_back(w4(mk(1, 0, 3, 0, 1, 10, 1, 0, 0, 0, 0, 0), 0, 3));
        // Three gaps: no forward for either depth.
        tbl.push_back(alu(3));
        for (int i = 0; i < 3; i++) tbl.push_back(bub());
        tbl.push_back(w4(mk(1, 0, 3, 0, 1, 10, 1, 0, 0, 0, 0, 0), 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(bub());
        // Back-to-back writers of r4: newest wins.
        tbl.push_back(alu(4));
        tbl.push_back(alu(4));
        tbl.push_back(w4(mk(1, 4, 0, 1, 0, 11, 1, 0, 0, 0, 1, 0), 1, 0));
        // Write to r0: forwarded only without a hardwired zero register.
        tbl.push_back(alu(0));
        tbl.push_back(w4(mk(1, 0, 0, 1, 0, 12, 1, 0, 0, 0, 1, 0), 0, 0));
        // Matching register but operands unused.
        tbl.push_back(alu(3));
        tbl.push_back(mk(1, 3, 3, 0, 0, 13, 1, 0, 0, 0, 0, 0));
        // Both operands forwarded.
        tbl.push_back(alu(8));
        tbl.push_back(w4(mk(1, 8, 8, 1, 1, 14, 1, 0, 0, 0, 1, 1), 1, 1));
        // Invalid decode slot never stalls.
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(bub());

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", -1, 32'(stall0), 32'd0);
        chk("rst_ex_valid", -1, 32'(exv0), 32'd0);
        chk("rst_sel_a", -1, 32'(sa0), 32'd0);
        chk("rst_sel_b", -1, 32'(sb0), 32'd0);
        chk("rst_stall_cnt", -1, scnt0, 32'd0);
        chk("rst_fwd_cnt", -1, fcnt0, 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (i == ph1_end) begin
                chk("stall_cnt", i, scnt0, PERF ? 32'd3 : 32'd0);
                chk("fwd_cnt", i, fcnt0, PERF ? 32'd1 : 32'd0);
            end
            apply(tbl[i], i);
        end

        // Reset in the middle of a load-use stall with a live forward select.
        apply(alu(3), 100);
        apply(w4(mk(1, 3, 0, 1, 0, 5, 1, 1, 0, 0, 1, 0), 1, 0), 101);
        drive(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 1, 0, 0));
        #3;
        chk("mid_stall", 102, 32'(stall0), 32'd1);
        chk("mid_stall4", 102, 32'(stall4), 32'd1);
        chk("mid_ex_valid", 102, 32'(exv0), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_stall", 103, 32'(stall0), 32'd0);
        chk("arst_stall4", 103, 32'(stall4), 32'd0);
        chk("arst_sel_a", 103, 32'(sa0), 32'd0);
        chk("arst_sel_a4", 103, 32'(sa4), 32'd0);
        chk("arst_ex_valid", 103, 32'(exv0), 32'd0);
        chk("arst_stall_cnt", 103, scnt0, 32'd0);
        chk("arst_stall_cnt4", 103, scnt4, 32'd0);
        chk("arst_fwd_cnt4", 103, fcnt4, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(bub());
        @(posedge clk);
        #1;
        chk("post_ex_valid4", 104, 32'(exv4), 32'd0);
        chk("post_sel_b4", 104, 32'(sb4), 32'd0);
        chk("post_fwd_cnt", 104, fcnt0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
